gmii_rx_deframer: RTL and testbench

GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

---
 rtl/gmii_rx_deframer_pkg.sv | 30 +++
 rtl/gmii_rx_deframer_if.sv | 29 ++
 rtl/eth_crc32_byte.sv | 18 +
 rtl/gmii_rx_deframer.sv | 164 ++++++++++++++++
 tb/tb_gmii_rx_deframer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_rx_deframer_pkg.sv
// Shared definitions for the GMII receive deframer: FSM encoding, Ethernet framing bytes
// and the CRC-32 constants.
package gmii_rx_deframer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0]  ETH_PRE     = 8'h55;
  localparam logic [7:0]  ETH_SFD     = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Five bytes held back so the four FCS bytes can be dropped at end of frame.
  localparam int          DLY_DEPTH   = 5;
  localparam logic [2:0]  DLY_FULL    = 3'd5;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

endpackage

// File: rtl/gmii_rx_deframer_if.sv
// GMII receive bus plus the outgoing byte stream and status pulses of the deframer.
interface gmii_rx_deframer_if;
  logic       clk_enable;
  logic       mii_select;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       stat_frame_good;
  logic       stat_frame_bad;
  logic       stat_runt;

  // master: PHY side driving GMII and consuming the stream
  modport master (
    output clk_enable, mii_select, gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  stat_frame_good, stat_frame_bad, stat_runt
  );

  // slave: the deframer
  modport slave (
    input  clk_enable, mii_select, gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output stat_frame_good, stat_frame_bad, stat_runt
  );
endinterface

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32, data consumed LSB first.
module eth_crc32_byte
  import gmii_rx_deframer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC_POLY_REFL;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII/MII receive deframer: strips preamble/SFD and FCS, flags bad frames on tlast.
//
// state    | meaning
// IDLE     | waiting for the first preamble byte
// PREAMBLE | inside 0x55 run, waiting for the SFD
// PAYLOAD  | frame body; bytes pass through a 5-byte delay line
// DROP     | malformed start, discard until dv falls
module gmii_rx_deframer
  import gmii_rx_deframer_pkg::*;
#(
  parameter bit CHECK_FCS = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  gmii_rx_deframer_if.slave rx
);

  rx_state_t                   state;
  logic                        mode_mii;
  logic                        nib_phase;
  logic [3:0]                  nib_lo;
  logic                        nib_er;
  logic [DLY_DEPTH-1:0][7:0]   dly;
  logic [2:0]                  dly_cnt;
  logic [31:0]                 crc;
  logic                        err_seen;

  logic [7:0] tdata_q;
  logic       tvalid_q, tlast_q, tuser_q;
  logic       good_q, bad_q, runt_q;

  logic       eff_mii, byte_stb, end_stb, byte_er, frame_bad;
  logic [7:0] byte_val;
  logic [31:0] crc_next;

  // Turn accepted GMII samples into byte and end-of-frame events.
  always_comb begin
    eff_mii  = (state == ST_IDLE && !nib_phase) ? rx.mii_select : mode_mii;
    byte_stb = 1'b0;
    end_stb  = 1'b0;
    byte_val = rx.gmii_rxd;
    byte_er  = rx.gmii_rx_er;
    if (rx.clk_enable) begin
      if (!rx.gmii_rx_dv) begin
        end_stb = 1'b1;
      end else if (!eff_mii) begin
        byte_stb = 1'b1;
      end else if (nib_phase) begin
        byte_stb = 1'b1;
        byte_val = {rx.gmii_rxd[3:0], nib_lo};
        byte_er  = rx.gmii_rx_er | nib_er;
      end
    end
  end

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (byte_val),
    .crc_out (crc_next)
  );

  assign frame_bad = err_seen | (CHECK_FCS && (crc != CRC_RESIDUE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_mii  <= 1'b0;
      nib_phase <= 1'b0;
      nib_lo    <= '0;
      nib_er    <= 1'b0;
      dly       <= '0;
      dly_cnt   <= '0;
      crc       <= CRC_INIT;
      err_seen  <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      runt_q    <= 1'b0;
    end else if (rx.clk_enable) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      runt_q   <= 1'b0;
      mode_mii <= eff_mii;

      if (!rx.gmii_rx_dv) begin
        nib_phase <= 1'b0;
      end else if (eff_mii) begin
        nib_phase <= !nib_phase;
        if (!nib_phase) begin
          nib_lo <= rx.gmii_rxd[3:0];
          nib_er <= rx.gmii_rx_er;
        end
      end

      case (state)
        ST_IDLE: begin
          if (byte_stb) state <= (byte_val == ETH_PRE) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (end_stb) begin
            state <= ST_IDLE;
          end else if (byte_stb) begin
            if (byte_er) begin
              state <= ST_DROP;
            end else if (byte_val == ETH_SFD) begin
              state    <= ST_PAYLOAD;
              dly_cnt  <= '0;
              crc      <= CRC_INIT;
              err_seen <= 1'b0;
            end else if (byte_val != ETH_PRE) begin
              state <= ST_DROP;
            end
          end
        end
        ST_PAYLOAD: begin
          if (end_stb) begin
            state <= ST_IDLE;
            if (dly_cnt == DLY_FULL) begin
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b1;
              tdata_q  <= dly[DLY_DEPTH-1];
              tuser_q  <= frame_bad;
              good_q   <= !frame_bad;
              bad_q    <= frame_bad;
            end else begin
              runt_q <= 1'b1;
            end
          end else if (byte_stb) begin
            dly      <= {dly[DLY_DEPTH-2:0], byte_val};
            crc      <= crc_next;
            err_seen <= err_seen | byte_er;
            if (dly_cnt == DLY_FULL) begin
              tvalid_q <= 1'b1;
              tdata_q  <= dly[DLY_DEPTH-1];
            end else begin
              dly_cnt <= dly_cnt + 3'd1;
            end
          end
        end
        ST_DROP: begin
          if (end_stb) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The registers advance only on enabled samples; a pulse is presented on the next
  // enabled cycle, so valid and status are masked whenever clk_enable is low.
  assign rx.m_axis_tdata    = tdata_q;
  assign rx.m_axis_tvalid   = tvalid_q & rx.clk_enable;
  assign rx.m_axis_tlast    = tlast_q;
  assign rx.m_axis_tuser    = tuser_q;
  assign rx.stat_frame_good = good_q & rx.clk_enable;
  assign rx.stat_frame_bad  = bad_q & rx.clk_enable;
  assign rx.stat_runt       = runt_q & rx.clk_enable;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: directed frames plus randomized traffic, checked
// against a frame-level reference model on both CHECK_FCS settings.
module tb_gmii_rx_deframer;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user_chk;
    logic       user_nochk;
  } beat_t;

  localparam logic [2:0] SV_GOOD = 3'b001;
  localparam logic [2:0] SV_BAD  = 3'b010;
  localparam logic [2:0] SV_RUNT = 3'b100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gmii_rx_deframer_if rx_a ();
  gmii_rx_deframer_if rx_b ();

  assign rx_b.clk_enable = rx_a.clk_enable;
  assign rx_b.mii_select = rx_a.mii_select;
  assign rx_b.gmii_rxd   = rx_a.gmii_rxd;
  assign rx_b.gmii_rx_dv = rx_a.gmii_rx_dv;
  assign rx_b.gmii_rx_er = rx_a.gmii_rx_er;

  gmii_rx_deframer #(.CHECK_FCS(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_a)
  );

  gmii_rx_deframer #(.CHECK_FCS(1'b0)) u_dut_nochk (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_b)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  beat_t      q_a[$];
  beat_t      q_b[$];
  logic [2:0] s_a[$];
  logic [2:0] s_b[$];
  logic [7:0] tx_b[$];
  bit         tx_e[$];
  int         ce_mode;
  bit         mii;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference Ethernet FCS (with final inversion) over tx_b[from +: cnt].
  function automatic logic [31:0] crc_of(input int from, input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = from; k < from + cnt; k++)
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ tx_b[k][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                   c = c >> 1;
      end
    return ~c;
  endfunction

  // ---------------- stimulus ----------------
  task automatic put_sample(input logic [7:0] d, input logic dv, input logic er);
    int gaps;
    gaps = 0;
    if (ce_mode == 1)      gaps = 1;
    else if (ce_mode == 2) gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) begin
      rx_a.clk_enable = 1'b0;
      rx_a.gmii_rxd   = 8'($urandom);
      rx_a.gmii_rx_dv = 1'($urandom);
      rx_a.gmii_rx_er = 1'($urandom);
      @(posedge clk); #1;
    end
    rx_a.clk_enable = 1'b1;
    rx_a.gmii_rxd   = d;
    rx_a.gmii_rx_dv = dv;
    rx_a.gmii_rx_er = er;
    @(posedge clk); #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit er);
    bit er_hi;
    if (mii) begin
      er_hi = 1'($urandom);
      put_sample({4'($urandom), b[3:0]}, 1'b1, er & !er_hi);
      put_sample({4'($urandom), b[7:4]}, 1'b1, er & er_hi);
    end else begin
      put_sample(b, 1'b1, er);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put_sample(8'($urandom), 1'b0, 1'b0);
  endtask

  // fcs_mode: 0 = no FCS appended, 1 = correct FCS, 2 = last FCS byte ^ 0x01
  task automatic build(input int pre_len, input int plen, input bit seq_pat,
                       input int fcs_mode, input int er_idx);
    int          start;
    logic [31:0] c;
    tx_b.delete();
    tx_e.delete();
    for (int k = 0; k < pre_len; k++) begin tx_b.push_back(8'h55); tx_e.push_back(1'b0); end
    tx_b.push_back(8'hD5); tx_e.push_back(1'b0);
    start = tx_b.size();
    for (int k = 0; k < plen; k++) begin
      tx_b.push_back(seq_pat ? 8'(k) : 8'($urandom));
      tx_e.push_back(k == er_idx);
    end
    if (fcs_mode != 0) begin
      c = crc_of(start, plen);
      if (fcs_mode == 2) c[31:24] = c[31:24] ^ 8'h01;
      for (int j = 0; j < 4; j++) begin tx_b.push_back(c[8*j +: 8]); tx_e.push_back(1'b0); end
    end
  endtask

  // Frame-level model: parse preamble/SFD, drop FCS, judge the frame from its FCS field.
  task automatic model();
    int          n, i, m;
    bit          er_any, bad;
    logic [31:0] fcs_rx;
    beat_t       bt;
    n = tx_b.size();
    if (n == 0 || tx_b[0] != 8'h55) return;
    i = 1;
    while (i < n && tx_b[i] == 8'h55 && !tx_e[i]) i++;
    if (i >= n) return;
    if (tx_b[i] != 8'hD5 || tx_e[i]) return;
    i++;
    m = n - i - 4;
    if (m < 1) begin
      s_a.push_back(SV_RUNT);
      s_b.push_back(SV_RUNT);
      return;
    end
    er_any = 1'b0;
    for (int k = i; k < n; k++) er_any |= tx_e[k];
    fcs_rx = {tx_b[n-1], tx_b[n-2], tx_b[n-3], tx_b[n-4]};
    bad = er_any || (crc_of(i, m) != fcs_rx);
    for (int k = 0; k < m; k++) begin
      bt.d          = tx_b[i+k];
      bt.last       = (k == m - 1);
      bt.user_chk   = bad;
      bt.user_nochk = er_any;
      q_a.push_back(bt);
      q_b.push_back(bt);
    end
    s_a.push_back(bad ? SV_BAD : SV_GOOD);
    s_b.push_back(er_any ? SV_BAD : SV_GOOD);
  endtask

  task automatic run_frame(input int gap);
    model();
    for (int k = 0; k < tx_b.size(); k++) put_byte(tx_b[k], tx_e[k]);
    idle(gap);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    beat_t      e;
    logic [2:0] sv;
    sv = {rx_a.stat_runt, rx_a.stat_frame_bad, rx_a.stat_frame_good};
    if (!rx_a.clk_enable) begin
      check("a_tvalid_ce_low", 32'(rx_a.m_axis_tvalid), 32'd0);
      check("a_stat_ce_low", 32'(sv), 32'd0);
    end
    if (rx_a.m_axis_tvalid) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_beat: got unexpected beat data 0x%02h, expected none", rx_a.m_axis_tdata);
      end else begin
        e = q_a.pop_front();
        check("a_tdata", 32'(rx_a.m_axis_tdata), 32'(e.d));
        check("a_tlast", 32'(rx_a.m_axis_tlast), 32'(e.last));
        if (e.last) begin
          check("a_tuser", 32'(rx_a.m_axis_tuser), 32'(e.user_chk));
          check("a_stat_on_tlast", 32'(sv[1:0]), e.user_chk ? 32'd2 : 32'd1);
        end else begin
          check("a_tuser_mid", 32'(rx_a.m_axis_tuser), 32'd0);
          check("a_stat_mid", 32'(sv), 32'd0);
        end
      end
    end
    if (sv != 3'b000) begin
      if (s_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_stat: got unexpected status 0x%0h, expected none", sv);
      end else begin
        check("a_stat", 32'(sv), 32'(s_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t      e;
    logic [2:0] sv;
    sv = {rx_b.stat_runt, rx_b.stat_frame_bad, rx_b.stat_frame_good};
    if (rx_b.m_axis_tvalid) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_beat: got unexpected beat data 0x%02h, expected none", rx_b.m_axis_tdata);
      end else begin
        e = q_b.pop_front();
        check("b_tdata", 32'(rx_b.m_axis_tdata), 32'(e.d));
        check("b_tlast", 32'(rx_b.m_axis_tlast), 32'(e.last));
        if (e.last) check("b_tuser", 32'(rx_b.m_axis_tuser), 32'(e.user_nochk));
      end
    end
    if (sv != 3'b000) begin
      if (s_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_stat: got unexpected status 0x%0h, expected none", sv);
      end else begin
        check("b_stat", 32'(sv), 32'(s_b.pop_front()));
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    beat_t bt;
    rst_n           = 1'b0;
    ce_mode         = 0;
    mii             = 1'b0;
    rx_a.clk_enable = 1'b1;
    rx_a.mii_select = 1'b0;
    rx_a.gmii_rxd   = 8'h55;
    rx_a.gmii_rx_dv = 1'b1;
    rx_a.gmii_rx_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tdata",  32'(rx_a.m_axis_tdata), 32'd0);
    check("rst_tvalid", 32'(rx_a.m_axis_tvalid), 32'd0);
    check("rst_tlast",  32'(rx_a.m_axis_tlast), 32'd0);
    check("rst_tuser",  32'(rx_a.m_axis_tuser), 32'd0);
    check("rst_stat",   32'({rx_a.stat_runt, rx_a.stat_frame_bad, rx_a.stat_frame_good}), 32'd0);
    @(posedge clk); #1;
    rx_a.gmii_rx_dv = 1'b0;
    rst_n = 1'b1;
    idle(4);

    // 1G, always enabled: good, bad FCS, er on payload byte 10
    build(7, 60, 1'b1, 1, -1); run_frame(12);
    build(7, 60, 1'b1, 2, -1); run_frame(12);
    build(7, 60, 1'b1, 1, 10); run_frame(12);

    // MII nibbles with clk_enable toggling
    mii = 1'b1; rx_a.mii_select = 1'b1; ce_mode = 1;
    build(7, 60, 1'b1, 1, -1); run_frame(12);
    mii = 1'b0; rx_a.mii_select = 1'b0; ce_mode = 0;
    idle(4);

    // runts and the shortest non-runt frame
    build(7, 3, 1'b0, 0, -1); run_frame(8);
    build(7, 4, 1'b0, 0, -1); run_frame(8);
    build(7, 5, 1'b0, 0, -1); run_frame(8);

    // bad start byte, bad preamble byte, then a normal frame
    build(7, 60, 1'b1, 1, -1); tx_b[0] = 8'h12; run_frame(8);
    build(5, 20, 1'b0, 1, -1); tx_b[2] = 8'h57; run_frame(8);
    build(7, 60, 1'b1, 1, -1); run_frame(12);

    // reset one cycle after payload byte 20: bytes 0..15 already left, no tlast
    build(7, 60, 1'b1, 1, -1);
    for (int k = 0; k < 16; k++) begin
      bt.d = 8'(k); bt.last = 1'b0; bt.user_chk = 1'b0; bt.user_nochk = 1'b0;
      q_a.push_back(bt);
      q_b.push_back(bt);
    end
    for (int k = 0; k < 8 + 21; k++) put_byte(tx_b[k], tx_e[k]);
    rst_n = 1'b0;
    put_sample(8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(6);
    build(7, 60, 1'b1, 1, -1); run_frame(12);

    // randomized traffic
    for (int f = 0; f < 30; f++) begin
      int pl, fm, ei, pre;
      mii = 1'($urandom);
      rx_a.mii_select = mii;
      ce_mode = $urandom_range(0, 2);
      pre = $urandom_range(1, 7);
      pl  = $urandom_range(1, 70);
      fm  = ($urandom_range(0, 9) < 7) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 2);
      ei  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, pl - 1) : -1;
      build(pre, pl, 1'b0, fm, ei);
      if ($urandom_range(0, 9) == 0) tx_b[$urandom_range(0, pre)] = 8'($urandom);
      run_frame($urandom_range(2, 12));
    end

    ce_mode = 0;
    idle(30);
    check("a_beats_left", 32'(q_a.size()), 32'd0);
    check("b_beats_left", 32'(q_b.size()), 32'd0);
    check("a_stats_left", 32'(s_a.size()), 32'd0);
    check("b_stats_left", 32'(s_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
